// File: rtl/atm_session_ctrl.sv
// ATM session controller: card check, PIN retries, amount, dispense, eject.
// Optional daily withdrawal cap enabled by defining ATM_DAILY_LIMIT_EN.
module atm_session_ctrl #(
  parameter int PIN_W        = 16,
  parameter int AMT_W        = 16,
  parameter int MAX_TRIES    = 3,
  parameter int TIMEOUT_CYC  = 255,
  parameter int PIN_VALID    = 1234,
  parameter int INIT_BALANCE = 10000,
  parameter int DAILY_LIMIT  = 20000
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           card_in,
  input  logic                           card_ok,
  input  logic                           pin_stb,
  input  logic [PIN_W-1:0]               pin_in,
  input  logic                           amt_stb,
  input  logic [AMT_W-1:0]               amount,
  output logic                           green,
  output logic                           red,
  output logic                           alarm,
  output logic                           card_inserted,
  output logic                           card_valid,
  output logic                           dispense,
  output logic [AMT_W-1:0]               dispense_amt,
  output logic                           reject,
  output logic                           timeout,
  output logic                           eject_card,
  output logic                           retain_card,
  output logic [AMT_W-1:0]               balance,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
  output logic [2:0]                     state
`ifdef ATM_DAILY_LIMIT_EN
  ,
  output logic                           limit_hit
`endif
);

  localparam int TW = $clog2(MAX_TRIES+1);
  localparam int CW = $clog2(TIMEOUT_CYC+1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CARD = 3'd1;
  localparam logic [2:0] S_PIN  = 3'd2;
  localparam logic [2:0] S_AMT  = 3'd3;
  localparam logic [2:0] S_DISP = 3'd4;
  localparam logic [2:0] S_EJCT = 3'd5;
  localparam logic [2:0] S_LOCK = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [TW-1:0]    tries_q, tries_d;
  logic [CW-1:0]    timer_q, timer_d;
  logic [AMT_W-1:0] bal_q, bal_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic             rej_q, rej_d;
  logic             to_q, to_d;
  logic             tmo;
  logic             counting;
  logic             over_lim;
  logic             bad_amt;

`ifdef ATM_DAILY_LIMIT_EN
  logic [AMT_W:0]   wd_q, wd_d;
  logic             lim_q, lim_d;
  logic [AMT_W+1:0] wd_sum;

  // Cumulative total including the pending request
  always_comb begin
    wd_sum   = {1'b0, wd_q} + {2'b00, amount};
    over_lim = wd_sum > (AMT_W+2)'(DAILY_LIMIT);
  end
`else
  assign over_lim = 1'b0;
`endif

  assign counting = (state_q == S_CARD) ||
                    (state_q == S_PIN)  ||
                    (state_q == S_AMT);
  assign tmo      = timer_q == CW'(TIMEOUT_CYC-1);
  assign bad_amt  = (amount == '0) || (amount > bal_q) || over_lim;

  // Next-state: card pull beats strobes, strobes beat timeout
  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    bal_d   = bal_q;
    amt_d   = amt_q;
    rej_d   = 1'b0;
    to_d    = 1'b0;
`ifdef ATM_DAILY_LIMIT_EN
    wd_d    = wd_q;
    lim_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (card_in) begin
          state_d = S_CARD;
          tries_d = TW'(MAX_TRIES);
        end
      end
      S_CARD: begin
        if (!card_in) begin
          state_d = S_IDLE;
        end else if (card_ok) begin
          state_d = S_PIN;
        end else if (tmo) begin
          state_d = S_EJCT;
          to_d    = 1'b1;
        end
      end
      S_PIN: begin
        if (!card_in) begin
          state_d = S_IDLE;
        end else if (pin_stb) begin
          if (pin_in == PIN_W'(PIN_VALID)) begin
            state_d = S_AMT;
          end else begin
            tries_d = tries_q - TW'(1);
            if (tries_q <= TW'(1)) state_d = S_LOCK;
          end
        end else if (tmo) begin
          state_d = S_EJCT;
          to_d    = 1'b1;
        end
      end
      S_AMT: begin
        if (!card_in) begin
          state_d = S_IDLE;
        end else if (amt_stb) begin
          if (bad_amt) begin
            rej_d   = 1'b1;
            state_d = S_EJCT;
`ifdef ATM_DAILY_LIMIT_EN
            lim_d   = over_lim;
`endif
          end else begin
            amt_d   = amount;
            state_d = S_DISP;
          end
        end else if (tmo) begin
          state_d = S_EJCT;
          to_d    = 1'b1;
        end
      end
      S_DISP: begin
        bal_d   = bal_q - amt_q;
        state_d = S_EJCT;
`ifdef ATM_DAILY_LIMIT_EN
        wd_d    = wd_q + {1'b0, amt_q};
`endif
      end
      S_EJCT: begin
        if (!card_in) state_d = S_IDLE;
      end
      S_LOCK: begin
        state_d = S_LOCK;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Inactivity timer restarts on any state change or strobe
  always_comb begin
    timer_d = '0;
    if ((state_d == state_q) && !pin_stb && !amt_stb && counting)
      timer_d = timer_q + CW'(1);
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tries_q <= TW'(MAX_TRIES);
      timer_q <= '0;
      bal_q   <= AMT_W'(INIT_BALANCE);
      amt_q   <= '0;
      rej_q   <= 1'b0;
      to_q    <= 1'b0;
`ifdef ATM_DAILY_LIMIT_EN
      wd_q    <= '0;
      lim_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      timer_q <= timer_d;
      bal_q   <= bal_d;
      amt_q   <= amt_d;
      rej_q   <= rej_d;
      to_q    <= to_d;
`ifdef ATM_DAILY_LIMIT_EN
      wd_q    <= wd_d;
      lim_q   <= lim_d;
`endif
    end
  end

  // Moore decode of the indicator and actuator levels
  always_comb begin
    green         = 1'b0;
    red           = 1'b0;
    alarm         = 1'b0;
    card_inserted = 1'b0;
    card_valid    = 1'b0;
    dispense      = 1'b0;
    eject_card    = 1'b0;
    retain_card   = 1'b0;
    case (state_q)
      S_IDLE: red = 1'b1;
      S_CARD: begin
        green         = 1'b1;
        card_inserted = 1'b1;
      end
      S_PIN, S_AMT: begin
        green         = 1'b1;
        card_inserted = 1'b1;
        card_valid    = 1'b1;
      end
      S_DISP: begin
        green         = 1'b1;
        card_inserted = 1'b1;
        card_valid    = 1'b1;
        dispense      = 1'b1;
      end
      S_EJCT: begin
        eject_card = 1'b1;
        red        = 1'b1;
      end
      S_LOCK: begin
        alarm       = 1'b1;
        retain_card = 1'b1;
        red         = 1'b1;
      end
      default: ;
    endcase
  end

  assign dispense_amt = dispense ? amt_q : '0;
  assign reject       = rej_q;
  assign timeout      = to_q;
  assign balance      = bal_q;
  assign tries_left   = tries_q;
  assign state        = state_q;
`ifdef ATM_DAILY_LIMIT_EN
  assign limit_hit    = lim_q;
`endif

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl.
// Daily-limit steps run only when ATM_DAILY_LIMIT_EN is defined.
module tb_atm_session_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        card_in = 1'b0;
  logic        card_ok = 1'b0;
  logic        pin_stb = 1'b0;
  logic [15:0] pin_in = '0;
  logic        amt_stb = 1'b0;
  logic [15:0] amount = '0;
  logic        green, red, alarm;
  logic        card_inserted, card_valid;
  logic        dispense;
  logic [15:0] dispense_amt;
  logic        reject, timeout;
  logic        eject_card, retain_card;
  logic [15:0] balance;
  logic [1:0]  tries_left;
  logic [2:0]  state;
`ifdef ATM_DAILY_LIMIT_EN
  logic        limit_hit;
`endif

  int total = 0;
  int bad   = 0;

  atm_session_ctrl #(
    .PIN_W(16), .AMT_W(16), .MAX_TRIES(3),
    .TIMEOUT_CYC(255), .PIN_VALID(1234),
    .INIT_BALANCE(10000), .DAILY_LIMIT(10000)
  ) dut (
    .clock(clock), .reset(reset),
    .card_in(card_in), .card_ok(card_ok),
    .pin_stb(pin_stb), .pin_in(pin_in),
    .amt_stb(amt_stb), .amount(amount),
    .green(green), .red(red), .alarm(alarm),
    .card_inserted(card_inserted),
    .card_valid(card_valid),
    .dispense(dispense),
    .dispense_amt(dispense_amt),
    .reject(reject), .timeout(timeout),
    .eject_card(eject_card),
    .retain_card(retain_card),
    .balance(balance),
    .tries_left(tries_left),
    .state(state)
`ifdef ATM_DAILY_LIMIT_EN
    ,
    .limit_hit(limit_hit)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pin(input logic [15:0] v);
    pin_in  = v;
    pin_stb = 1'b1;
    tick();
    pin_stb = 1'b0;
  endtask

  task automatic amt(input logic [15:0] v);
    amount  = v;
    amt_stb = 1'b1;
    tick();
    amt_stb = 1'b0;
  endtask

  task automatic enter_pin_state();
    card_in = 1'b1;
    tick();
    card_ok = 1'b1;
    tick();
    card_ok = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_state", state, 0);
    chk("rst_red", red, 1);
    chk("rst_green", green, 0);
    chk("rst_bal", balance, 10000);
    chk("rst_tries", tries_left, 3);
    chk("rst_disp", dispense, 0);
    reset = 1'b0;
    tick();

    // 1: normal withdrawal of 500
    card_in = 1'b1;
    tick();
    chk("t1_card", state, 1);
    chk("t1_cardins", card_inserted, 1);
    chk("t1_green", green, 1);
    card_ok = 1'b1;
    tick();
    card_ok = 1'b0;
    chk("t1_pin", state, 2);
    chk("t1_valid", card_valid, 1);
    pin(16'd1234);
    chk("t1_amt", state, 3);
    amt(16'd500);
    chk("t1_disp_st", state, 4);
    chk("t1_disp", dispense, 1);
    chk("t1_disp_amt", dispense_amt, 500);
    chk("t1_bal_pre", balance, 10000);
    tick();
    chk("t1_eject_st", state, 5);
    chk("t1_bal", balance, 9500);
    chk("t1_disp_off", dispense, 0);
    chk("t1_eject", eject_card, 1);
    card_in = 1'b0;
    tick();
    chk("t1_idle", state, 0);

    // 2: three wrong PINs lock the card
    enter_pin_state();
    chk("t2_tries3", tries_left, 3);
    pin(16'd1111);
    chk("t2_tries2", tries_left, 2);
    chk("t2_st_pin", state, 2);
    pin(16'd1111);
    chk("t2_tries1", tries_left, 1);
    pin(16'd1111);
    chk("t2_tries0", tries_left, 0);
    chk("t2_lock", state, 6);
    chk("t2_alarm", alarm, 1);
    chk("t2_retain", retain_card, 1);
    card_in = 1'b0;
    tick();
    tick();
    chk("t2_held", state, 6);
    #2 reset = 1'b1;
    #1;
    chk("t2_rst_st", state, 0);
    chk("t2_rst_bal", balance, 10000);
    reset = 1'b0;
    tick();

    // 3: one wrong PIN, then over-balance amount
    enter_pin_state();
    pin(16'd1111);
    pin(16'd1234);
    chk("t3_amt", state, 3);
    chk("t3_tries", tries_left, 2);
    amt(16'd20000);
    chk("t3_eject", state, 5);
    chk("t3_reject", reject, 1);
    chk("t3_bal", balance, 10000);
    tick();
    chk("t3_rej_off", reject, 0);
    card_in = 1'b0;
    tick();
    chk("t3_idle", state, 0);

    // 3b: zero amount refused
    enter_pin_state();
    pin(16'd1234);
    amt(16'd0);
    chk("t3b_reject", reject, 1);
    chk("t3b_eject", state, 5);
    card_in = 1'b0;
    tick();

    // 4: PIN inactivity timeout
    enter_pin_state();
    for (int i = 0; i < 254; i++) tick();
    chk("t4_still_pin", state, 2);
    chk("t4_no_to", timeout, 0);
    tick();
    chk("t4_eject", state, 5);
    chk("t4_timeout", timeout, 1);
    tick();
    chk("t4_to_off", timeout, 0);
    card_in = 1'b0;
    tick();
    chk("t4_idle", state, 0);

    // 4b: strobe on the limit cycle wins
    enter_pin_state();
    for (int i = 0; i < 254; i++) tick();
    pin(16'd1234);
    chk("t4b_amt", state, 3);
    chk("t4b_no_to", timeout, 0);

    // 5: card pulled in AMOUNT
    card_in = 1'b0;
    tick();
    chk("t5_idle", state, 0);
    chk("t5_nodisp", dispense, 0);
    chk("t5_bal", balance, 10000);

    // 5b: reset during DISPENSE
    enter_pin_state();
    pin(16'd1234);
    amt(16'd300);
    chk("t5b_disp", dispense, 1);
    #2 reset = 1'b1;
    #1;
    chk("t5b_idle", state, 0);
    chk("t5b_bal", balance, 10000);
    chk("t5b_nodisp", dispense, 0);
    reset = 1'b0;
    tick();
    chk("t5b_bal2", balance, 10000);
    card_in = 1'b0;
    tick();

`ifdef ATM_DAILY_LIMIT_EN
    // 6: daily cap of 10000
    enter_pin_state();
    pin(16'd1234);
    amt(16'd9000);
    tick();
    chk("t6_bal1", balance, 1000);
    card_in = 1'b0;
    tick();
    enter_pin_state();
    pin(16'd1234);
    amt(16'd2000);
    chk("t6_reject", reject, 1);
    chk("t6_limit", limit_hit, 1);
    chk("t6_bal2", balance, 1000);
    card_in = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
Parametrised ATM session controller. It sequences card entry, card check, PIN entry with a configurable retry limit, amount request, cash dispense and card eject/retain. Unlike the earlier fixed-width controller, it holds a real balance register that is debited on each withdrawal. It adds per-state inactivity timeouts and card-pull abort, and reports a strobe-driven outcome. It sits between the keypad/card-reader front end and the dispenser/LED driver logic.

Parameters:
PIN_W, 16, width of PIN bus
AMT_W, 16, width of amount and balance
MAX_TRIES, 3, PIN attempts before card retention (>=1)
TIMEOUT_CYC, 255, idle cycles allowed in CARD/PIN/AMOUNT before forced eject (>=1)
PIN_VALID, 1234, accepted PIN value
INIT_BALANCE, 10000, balance loaded at reset
DAILY_LIMIT, 20000, cumulative withdrawal cap (used only with ATM_DAILY_LIMIT_EN)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
card_in  in  1  level, card physically present
card_ok  in  1  card reader verdict, sampled in CARD
pin_stb  in  1  one-cycle strobe, pin_in valid
pin_in  in  PIN_W  entered PIN
amt_stb  in  1  one-cycle strobe, amount valid
amount  in  AMT_W  requested amount
green, red, alarm  out  1  indicators
card_inserted, card_valid  out  1  status
dispense  out  1  one-cycle dispense pulse
dispense_amt  out  AMT_W  amount being dispensed, valid with dispense
reject  out  1  one-cycle pulse: amount refused
timeout  out  1  one-cycle pulse: inactivity timeout fired
eject_card, retain_card  out  1  card actuator commands
balance  out  AMT_W  current balance
tries_left  out  $clog2(MAX_TRIES+1)  remaining PIN attempts
state  out  3  current state code

Behaviour:
- States: IDLE=0, CARD=1, PIN=2, AMOUNT=3, DISPENSE=4, EJECT=5, LOCK=6; code 7 is illegal and recovers to IDLE next cycle.
- Reset (async, high): state=IDLE, balance=INIT_BALANCE, tries_left=MAX_TRIES, timer=0, latched amount=0. All pulse outputs are 0. Level outputs take their IDLE decode.
- Level outputs are Moore outputs decoded from state:
  - IDLE: red=1, all others 0.
  - CARD: green=1, card_inserted=1.
  - PIN/AMOUNT: green=1, card_inserted=1, card_valid=1.
  - DISPENSE: green=1, card_inserted=1, card_valid=1, dispense=1.
  - EJECT: eject_card=1, red=1.
  - LOCK: alarm=1, retain_card=1, red=1.
- IDLE -> CARD when card_in=1. tries_left is reloaded to MAX_TRIES.
- CARD: card_ok=1 -> PIN. card_ok=0 -> stay; the timer governs exit.
- PIN, on pin_stb:
  - pin_in==PIN_VALID -> AMOUNT.
  - Otherwise tries_left decrements. If it reaches 0 -> LOCK, else stay in PIN.
- AMOUNT, on amt_stb:
  - amount==0 or amount>balance -> reject pulse, then EJECT.
  - Otherwise latch amount, then DISPENSE.
- DISPENSE lasts exactly one cycle. dispense_amt equals the latched amount. On the exiting edge balance <= balance - amount, and the state goes to EJECT. Underflow is impossible by construction.
- EJECT -> IDLE when card_in=0.
- LOCK is held until reset; card_in is ignored.
- Timer: clears on every state change and on any pin_stb/amt_stb. It counts in CARD/PIN/AMOUNT. When it reaches TIMEOUT_CYC it emits a timeout pulse and goes to EJECT.
- Card pulled: card_in=0 in CARD/PIN/AMOUNT -> IDLE next cycle, with no dispense and no balance change.
- Priority within a cycle: card pull > strobe > timeout. If a strobe and the timer limit coincide, the strobe is processed.
- Strobes outside their own state are ignored.
- Latency: strobe at edge N -> new state visible after edge N+1. amt_stb accepted at N -> dispense high during cycle N+1 -> balance updated at edge N+2.
- Reset mid-DISPENSE: no debit occurs, and balance returns to INIT_BALANCE.

Optional Feature:
ATM_DAILY_LIMIT_EN:
- When defined:
  - A withdrawn_total register (AMT_W+1 bits, reset 0) accumulates each dispensed amount.
  - AMOUNT also rejects when withdrawn_total+amount > DAILY_LIMIT.
  - An extra output limit_hit pulses with reject in that case.
- When undefined: no register, no port, and no limit check.

Test Plan:
1. Reset, card_in=1, card_ok=1, pin_in=1234, amount=500 -> dispense pulse with dispense_amt=500, balance 10000->9500, EJECT; card_in=0 -> IDLE.
2. Wrong PIN 1111 three times -> tries_left 3->2->1->0, LOCK, alarm=1, retain_card=1, held until reset.
3. Wrong PIN once, then 1234 -> tries_left=2, AMOUNT; amount=20000 -> reject pulse, EJECT, balance stays 10000.
4. In PIN with no strobes for 255 cycles -> timeout pulse on the 255th cycle, EJECT. A pin_stb on the same cycle overrides the timeout.
5. card_in dropped in AMOUNT -> IDLE, no dispense. Async reset asserted mid-DISPENSE -> IDLE immediately, balance=10000.
6. With ATM_DAILY_LIMIT_EN, withdraw 9000 then 2000 with DAILY_LIMIT=10000 -> second request gets reject plus limit_hit, balance=1000.
